// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: program counter side, instruction cache side and decode side.
// The master modport is the fetch unit; slave is the surrounding pipeline and cache.
interface fetch_unit_if;
    logic [31:0] pcaddr;
    logic        ihit;
    logic        flush;
    logic        halt;
    logic        iREN;
    logic [31:0] iaddr;
    logic        imem_ack;
    logic [31:0] iload;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    modport master (
        input  pcaddr, flush, halt, imem_ack, iload, instr_ready,
        output ihit, iREN, iaddr, instr_valid, instr, instr_pc
    );

    modport slave (
        output pcaddr, flush, halt, imem_ack, iload, instr_ready,
        input  ihit, iREN, iaddr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding cache reads feeding a small fetch queue.
// Define FETCH_PERF_EN to add saturating fetch/drop performance counters.
module fetch_unit #(
    parameter int          FQ_DEPTH = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          CLK,
    input  logic          RST,
    fetch_unit_if.master  fif
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]   perf_fetch_cnt,
    output logic [31:0]   perf_drop_cnt
`endif
);
    localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FQ_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state_q, state_d;
    logic [31:0]       iaddr_q, iaddr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       instr_mem_q [FQ_DEPTH];
    logic [31:0]       instr_mem_d [FQ_DEPTH];
    logic [31:0]       pc_mem_q    [FQ_DEPTH];
    logic [31:0]       pc_mem_d    [FQ_DEPTH];

    logic ihit;
    logic push;
    logic pop;
    logic discard;
    logic instr_valid;

    always_comb begin
        state_d = state_q;
        iaddr_d = iaddr_q;
        ihit    = 1'b0;
        push    = 1'b0;
        discard = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fif.flush && !fif.halt && (count_q < CNT_FULL)) begin
                    state_d = REQ;
                    iaddr_d = fif.pcaddr;
                end
            end
            REQ: begin
                if (fif.imem_ack) begin
                    state_d = IDLE;
                    if (fif.flush) begin
                        discard = 1'b1;
                    end else begin
                        ihit = 1'b1;
                        push = 1'b1;
                    end
                end else if (fif.flush) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                // The cache still owes us this response, so keep requesting until it arrives.
                if (fif.imem_ack) begin
                    state_d = IDLE;
                    discard = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_valid = (count_q != '0);
    assign pop         = instr_valid && fif.instr_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        if (fif.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_mem_d[wr_ptr_q] = fif.iload;
                pc_mem_d[wr_ptr_q]    = iaddr_q;
                wr_ptr_d              = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            iaddr_q  <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FQ_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else begin
            state_q     <= state_d;
            iaddr_q     <= iaddr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            instr_mem_q <= instr_mem_d;
            pc_mem_q    <= pc_mem_d;
        end
    end

    assign fif.ihit        = ihit;
    assign fif.iREN        = (state_q != IDLE);
    assign fif.iaddr       = iaddr_q;
    assign fif.instr_valid = instr_valid;
    assign fif.instr       = instr_mem_q[rd_ptr_q];
    assign fif.instr_pc    = pc_mem_q[rd_ptr_q];

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_drop_q, perf_drop_d;
    logic [32:0] drop_sum;

    // A flush counts every entry still in the queue as dropped, even one decode pops that cycle.
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        if (ihit && (perf_fetch_q != 32'hFFFF_FFFF)) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        drop_sum = {1'b0, perf_drop_q} + 33'(discard);
        if (fif.flush) begin
            drop_sum = drop_sum + 33'(count_q);
        end
        perf_drop_d = drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            perf_fetch_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: a per-cycle vector table plus hand-written corner sequences.
// Inputs change on the falling edge; outputs are checked 1ns later, well away from the rising edge.
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_BEE0;
    localparam logic [31:0] I0 = 32'hA000_0001;
    localparam logic [31:0] I1 = 32'hA111_0002;
    localparam logic [31:0] I2 = 32'hA222_0003;
    localparam logic [31:0] I3 = 32'hA333_0004;
    localparam logic [31:0] I4 = 32'hA444_0005;
    localparam logic [31:0] I5 = 32'hA555_0006;
    localparam logic [31:0] I6 = 32'hA666_0007;
    localparam logic [31:0] I7 = 32'hA777_0008;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    typedef struct {
        logic        rst;
        logic [31:0] pcaddr;
        logic        flush;
        logic        halt;
        logic        ack;
        logic [31:0] iload;
        logic        ready;
        logic        exp_iren;
        logic [31:0] exp_iaddr;
        logic        exp_ihit;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic [31:0] exp_pc;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];

    fetch_unit_if fif();

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_drop_cnt;
`endif

    fetch_unit #(.FQ_DEPTH(2), .RESET_PC(RST_PC)) dut (
        .CLK(clk),
        .RST(rst),
        .fif(fif)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt(perf_fetch_cnt),
        .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic [31:0] pc, logic fl, logic hl, logic ak,
                                logic [31:0] ld, logic rdy, logic e_iren, logic [31:0] e_iaddr,
                                logic e_ihit, logic e_valid, logic [31:0] e_instr,
                                logic [31:0] e_pc);
        vec_t v;
        v.rst = r;  v.pcaddr = pc;  v.flush = fl;  v.halt = hl;  v.ack = ak;
        v.iload = ld;  v.ready = rdy;
        v.exp_iren = e_iren;  v.exp_iaddr = e_iaddr;  v.exp_ihit = e_ihit;
        v.exp_valid = e_valid;  v.exp_instr = e_instr;  v.exp_pc = e_pc;
        return v;
    endfunction

    task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(vec_t v);
        @(negedge clk);
        rst             = v.rst;
        fif.pcaddr      = v.pcaddr;
        fif.flush       = v.flush;
        fif.halt        = v.halt;
        fif.imem_ack    = v.ack;
        fif.iload       = v.iload;
        fif.instr_ready = v.ready;
    endtask

    task automatic check_output(vec_t v, string tag);
        #1;
        check_val({tag, ".iREN"},        32'(fif.iREN),        32'(v.exp_iren));
        check_val({tag, ".iaddr"},       fif.iaddr,            v.exp_iaddr);
        check_val({tag, ".ihit"},        32'(fif.ihit),        32'(v.exp_ihit));
        check_val({tag, ".instr_valid"}, 32'(fif.instr_valid), 32'(v.exp_valid));
        if (v.exp_valid) begin
            check_val({tag, ".instr"},    fif.instr,    v.exp_instr);
            check_val({tag, ".instr_pc"}, fif.instr_pc, v.exp_pc);
        end
    endtask

    task automatic run_vec(vec_t v, string tag);
        apply_stimulus(v);
        check_output(v, tag);
    endtask

    initial begin
        rst             = 1'b1;
        fif.pcaddr      = '0;
        fif.flush       = 1'b0;
        fif.halt        = 1'b0;
        fif.imem_ack    = 1'b0;
        fif.iload       = '0;
        fif.instr_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Straight-line fetch with a 1-cycle cache and decode always ready
        tbl.push_back(mk(0, 32'h00, 0, 0, 0, '0, 1,  0, RST_PC, 0, 0, '0, '0));
        tbl.push_back(mk(0, 32'h00, 0, 0, 1, I0, 1,  1, 32'h00, 1, 0, '0, '0));
        tbl.push_back(mk(0, 32'h04, 0, 0, 0, '0, 1,  0, 32'h00, 0, 1, I0, 32'h00));
        tbl.push_back(mk(0, 32'h04, 0, 0, 1, I1, 1,  1, 32'h04, 1, 0, '0, '0));
        tbl.push_back(mk(0, 32'h08, 0, 0, 0, '0, 1,  0, 32'h04, 0, 1, I1, 32'h04));
        tbl.push_back(mk(0, 32'h08, 0, 0, 1, I2, 1,  1, 32'h08, 1, 0, '0, '0));
        tbl.push_back(mk(0, 32'h0C, 0, 1, 0, '0, 1,  0, 32'h08, 0, 1, I2, 32'h08));
        tbl.push_back(mk(0, 32'h0C, 0, 1, 0, '0, 1,  0, 32'h08, 0, 0, '0, '0));
        // Backpressure: fill both entries, stall, then drain across the pointer wrap
        tbl.push_back(mk(0, 32'h10, 0, 0, 0, '0, 0,  0, 32'h08, 0, 0, '0, '0));
        tbl.push_back(mk(0, 32'h10, 0, 0, 1, I3, 0,  1, 32'h10, 1, 0, '0, '0));
        tbl.push_back(mk(0, 32'h14, 0, 0, 0, '0, 0,  0, 32'h10, 0, 1, I3, 32'h10));
        tbl.push_back(mk(0, 32'h14, 0, 0, 1, I4, 0,  1, 32'h14, 1, 1, I3, 32'h10));
        tbl.push_back(mk(0, 32'h18, 0, 0, 0, '0, 0,  0, 32'h14, 0, 1, I3, 32'h10));
        tbl.push_back(mk(0, 32'h18, 0, 0, 0, '0, 0,  0, 32'h14, 0, 1, I3, 32'h10));
        tbl.push_back(mk(0, 32'h18, 0, 0, 0, '0, 1,  0, 32'h14, 0, 1, I3, 32'h10));
        tbl.push_back(mk(0, 32'h18, 0, 0, 0, '0, 0,  0, 32'h14, 0, 1, I4, 32'h14));
        tbl.push_back(mk(0, 32'h18, 0, 0, 1, I5, 1,  1, 32'h18, 1, 1, I4, 32'h14));
        tbl.push_back(mk(0, 32'h1C, 0, 1, 0, '0, 1,  0, 32'h18, 0, 1, I5, 32'h18));
        tbl.push_back(mk(0, 32'h1C, 0, 1, 0, '0, 1,  0, 32'h18, 0, 0, '0, '0));

        foreach (tbl[i]) begin
            run_vec(tbl[i], $sformatf("row%0d", i));
        end

        // Flush in the first wait cycle of a 3-cycle cache access
        run_vec(mk(0, 32'h20, 0, 0, 0, '0,   0,  0, 32'h18, 0, 0, '0, '0), "drop0");
        run_vec(mk(0, 32'h20, 1, 0, 0, '0,   0,  1, 32'h20, 0, 0, '0, '0), "drop1");
        run_vec(mk(0, 32'h40, 0, 0, 0, '0,   0,  1, 32'h20, 0, 0, '0, '0), "drop2");
        run_vec(mk(0, 32'h40, 0, 0, 1, JUNK, 0,  1, 32'h20, 0, 0, '0, '0), "drop3");
        run_vec(mk(0, 32'h40, 0, 0, 0, '0,   0,  0, 32'h20, 0, 0, '0, '0), "drop4");
        run_vec(mk(0, 32'h40, 0, 0, 1, I6,   0,  1, 32'h40, 1, 0, '0, '0), "drop5");

        // Flush coincident with ack and with a pop of the single queued entry
        run_vec(mk(0, 32'h44, 0, 0, 0, '0,   0,  0, 32'h40, 0, 1, I6, 32'h40), "fack0");
        run_vec(mk(0, 32'h44, 1, 0, 1, JUNK, 1,  1, 32'h44, 0, 1, I6, 32'h40), "fack1");
        run_vec(mk(0, 32'h80, 0, 1, 0, '0,   1,  0, 32'h44, 0, 0, '0, '0), "fack2");
`ifdef FETCH_PERF_EN
        check_val("perf_fetch", perf_fetch_cnt, 32'd7);
        check_val("perf_drop",  perf_drop_cnt,  32'd3);
`endif

        // Halt raised while a request is outstanding
        run_vec(mk(0, 32'h80, 0, 0, 0, '0, 0,  0, 32'h44, 0, 0, '0, '0), "halt0");
        run_vec(mk(0, 32'h80, 0, 1, 0, '0, 0,  1, 32'h80, 0, 0, '0, '0), "halt1");
        run_vec(mk(0, 32'h80, 0, 1, 1, I7, 0,  1, 32'h80, 1, 0, '0, '0), "halt2");
        run_vec(mk(0, 32'h84, 0, 1, 0, '0, 0,  0, 32'h80, 0, 1, I7, 32'h80), "halt3");
        run_vec(mk(0, 32'h84, 0, 1, 0, '0, 0,  0, 32'h80, 0, 1, I7, 32'h80), "halt4");
        run_vec(mk(0, 32'h84, 0, 0, 0, '0, 0,  0, 32'h80, 0, 1, I7, 32'h80), "halt5");
        run_vec(mk(0, 32'h84, 0, 0, 0, '0, 0,  1, 32'h84, 0, 1, I7, 32'h80), "halt6");

        // Reset asserted while a request is outstanding
        run_vec(mk(1, 32'h84, 0, 0, 0, '0, 0,  1, 32'h84, 0, 1, I7, 32'h80), "rst0");
        run_vec(mk(0, 32'h84, 0, 1, 0, '0, 0,  0, RST_PC, 0, 0, '0, '0), "rst1");
`ifdef FETCH_PERF_EN
        check_val("perf_fetch_rst", perf_fetch_cnt, 32'd0);
        check_val("perf_drop_rst",  perf_drop_cnt,  32'd0);
`endif

        // Flush in IDLE blocks issue for one cycle, then the new target is fetched
        run_vec(mk(0, 32'h90, 1, 0, 0, '0, 0,  0, RST_PC, 0, 0, '0, '0), "fidle0");
        run_vec(mk(0, 32'h90, 0, 0, 0, '0, 0,  0, RST_PC, 0, 0, '0, '0), "fidle1");
        run_vec(mk(0, 32'h90, 0, 0, 0, '0, 0,  1, 32'h90, 0, 0, '0, '0), "fidle2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
